sequencer_ctrl: RTL

SEQUENCER_CTRL -- requirements
Module: sequencer_ctrl

---
 rtl/sequencer_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sequencer_ctrl.sv
// Sequencer control: loads the sequencer LUT from a host stream, arms and runs the
// sequencer, and manages the exit handshake with a completion timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first LUT entry of a new load
// LOAD  | accepting LUT entries until the entry flagged last
// ARM   | LUT complete, waiting for a run request
// RUN   | sequencer running, counting completed frames
// STOP  | exit requested, waiting for sequence_done_i or timeout
// ERROR | LUT overflow or stop timeout, held until cleared
module sequencer_ctrl #(
    parameter int MAX_ENTRIES  = 256,
    parameter int STOP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [36:0] cfg_data_i,
    input  logic        cfg_last_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_err_i,
    output logic        lut_wen_o,
    output logic [36:0] lut_write_data_o,
    output logic        config_done_o,
    output logic        exit_signal_o,
    input  logic        sequence_done_i,
    output logic [2:0]  state_o,
    output logic [8:0]  entry_count_o,
    output logic [15:0] frame_count_o,
    output logic        done_pulse_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int               TW       = $clog2(STOP_TIMEOUT + 1);
    localparam logic [TW-1:0]    TMR_LOAD = TW'(STOP_TIMEOUT - 1);
    localparam logic [8:0]       MAX_CNT  = 9'(MAX_ENTRIES);

    state_t          state;
    state_t          state_nxt;
    logic            rst_meta;
    logic            rst_n;
    logic            done_q;
    logic [TW-1:0]   stop_tmr;
    logic            hs;
    logic            wr;
    logic            done_rise;

    // Reset asserts immediately but releases only after two clk edges.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_comb begin
        hs        = cfg_valid_i & cfg_ready_o;
        wr        = hs && ((state == ST_IDLE) || (entry_count_o != MAX_CNT));
        done_rise = sequence_done_i & ~done_q;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hs) state_nxt = cfg_last_i ? ST_ARM : ST_LOAD;
            end
            ST_LOAD: begin
                if (hs) begin
                    if (entry_count_o == MAX_CNT) state_nxt = ST_ERROR;
                    else if (cfg_last_i)          state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (stop_i)       state_nxt = ST_IDLE;
                else if (start_i) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop_i) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (sequence_done_i)    state_nxt = ST_IDLE;
                else if (stop_tmr == '0) state_nxt = ST_ERROR;
            end
            ST_ERROR: begin
                if (clear_err_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered so they line up with state_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cfg_ready_o      <= 1'b0;
            lut_wen_o        <= 1'b0;
            lut_write_data_o <= '0;
            config_done_o    <= 1'b0;
            exit_signal_o    <= 1'b0;
            entry_count_o    <= '0;
            frame_count_o    <= '0;
            done_pulse_o     <= 1'b0;
            error_o          <= 1'b0;
            done_q           <= 1'b0;
            stop_tmr         <= TMR_LOAD;
        end else begin
            state         <= state_nxt;
            cfg_ready_o   <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
            config_done_o <= (state_nxt == ST_RUN) || (state_nxt == ST_STOP);
            exit_signal_o <= (state_nxt == ST_STOP);
            done_pulse_o  <= (state == ST_STOP) && (state_nxt == ST_IDLE);
            error_o       <= (state_nxt == ST_ERROR);
            lut_wen_o     <= wr;
            done_q        <= sequence_done_i;

            if (wr) lut_write_data_o <= cfg_data_i;

            if (hs && (state == ST_IDLE)) entry_count_o <= 9'd1;
            else if (wr)                  entry_count_o <= entry_count_o + 9'd1;

            if (hs && (state == ST_IDLE))
                frame_count_o <= '0;
            else if ((state == ST_RUN) && done_rise && (frame_count_o != 16'hFFFF))
                frame_count_o <= frame_count_o + 16'd1;

            if (state != ST_STOP)    stop_tmr <= TMR_LOAD;
            else if (stop_tmr != '0) stop_tmr <= stop_tmr - 1'b1;
        end
    end

    assign state_o = state;

endmodule
